// File: rtl/mult_booth_seq.sv
// Sequential radix-2 Booth multiplier: 32 iterations per product.
// Outputs are the low 32 product bits, a signed-overflow flag and a ready pulse.
//
// state | meaning
// IDLE  | waiting for ctrl_MULT
// RUN   | one Booth step per clock, 32 steps
// DONE  | result registers valid, data_resultRDY high for this cycle
module mult_booth_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   mcand;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mq;
  logic             q_m1;
  logic [5:0]       count;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   nacc;
  logic [WIDTH-1:0] nmq;
  logic             nq_m1;
  logic [WIDTH:0]   hi_bits;
  logic             ovf;

  // One Booth step: conditional add/subtract, then arithmetic shift of {acc, mq, q_m1}.
  always_comb begin
    sum = acc;
    case ({mq[0], q_m1})
      2'b01:   sum = acc + mcand;
      2'b10:   sum = acc - mcand;
      default: sum = acc;
    endcase
    {nacc, nmq, nq_m1} = {sum[WIDTH], sum, mq};
    hi_bits = {nacc[WIDTH-1:0], nmq[WIDTH-1]};
    ovf = !((hi_bits == '0) || (hi_bits == '1));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      mcand          <= '0;
      acc            <= '0;
      mq             <= '0;
      q_m1           <= 1'b0;
      count          <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else if (ctrl_MULT) begin
      // A start in any state discards whatever was in flight.
      state          <= RUN;
      mcand          <= {data_operandA[WIDTH-1], data_operandA};
      acc            <= '0;
      mq             <= data_operandB;
      q_m1           <= 1'b0;
      count          <= '0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b1;
    end else begin
      case (state)
        RUN: begin
          acc   <= nacc;
          mq    <= nmq;
          q_m1  <= nq_m1;
          count <= count + 6'd1;
          if (count == 6'd31) begin
            state          <= DONE;
            data_result    <= nmq;
            data_exception <= ovf;
            data_resultRDY <= 1'b1;
            busy           <= 1'b0;
          end
        end
        DONE: begin
          state          <= IDLE;
          data_resultRDY <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          data_resultRDY <= 1'b0;
          busy           <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_booth_seq.sv
// Directed-vector bench for mult_booth_seq: latency, products, overflow,
// restart, asynchronous reset and back-to-back operation.
module tb_mult_booth_seq;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int lat;
  int bcnt;
  int rdy_seen;

  logic [31:0] va [6];
  logic [31:0] vb [6];
  logic [31:0] vr [6];
  logic        ve [6];

  mult_booth_seq #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start pulse sampled on one rising edge (E0); returns #1 after E0.
  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    data_operandA = 32'hDEAD_BEEF;
    data_operandB = 32'h1234_5678;
  endtask

  // Counts edges after E0 until the ready pulse (bounded), and busy-high samples.
  task automatic wait_rdy(output int l, output int bc);
    l  = 0;
    bc = busy ? 1 : 0;
    while (l < 60) begin
      @(posedge clock);
      #1;
      l++;
      if (data_resultRDY) break;
      if (busy) bc++;
    end
  endtask

  initial begin
    va[0] = 32'hFFFF_FFFD; vb[0] = 32'd5;         vr[0] = 32'hFFFF_FFF1; ve[0] = 1'b0;
    va[1] = 32'h8000_0000; vb[1] = 32'd1;         vr[1] = 32'h8000_0000; ve[1] = 1'b0;
    va[2] = 32'h0001_0000; vb[2] = 32'h0001_0000; vr[2] = 32'h0000_0000; ve[2] = 1'b1;
    va[3] = 32'h8000_0000; vb[3] = 32'hFFFF_FFFF; vr[3] = 32'h8000_0000; ve[3] = 1'b1;
    va[4] = 32'h7FFF_FFFF; vb[4] = 32'd2;         vr[4] = 32'hFFFF_FFFE; ve[4] = 1'b1;
    va[5] = 32'h8000_0000; vb[5] = 32'h8000_0000; vr[5] = 32'h0000_0000; ve[5] = 1'b1;

    reset_n = 1'b0;
    ctrl_MULT = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #12;
    chk("rst_result", data_result, 32'd0);
    chk("rst_exc", {31'd0, data_exception}, 32'd0);
    chk("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // 6 x 7: latency, busy length, single-cycle pulse
    do_start(32'd6, 32'd7);
    wait_rdy(lat, bcnt);
    chk("basic_lat", lat, 32'd32);
    chk("basic_busy_cycles", bcnt, 32'd32);
    chk("basic_result", data_result, 32'd42);
    chk("basic_exc", {31'd0, data_exception}, 32'd0);
    @(posedge clock); #1;
    chk("basic_rdy_one_cycle", {31'd0, data_resultRDY}, 32'd0);
    chk("basic_result_hold", data_result, 32'd42);
    chk("basic_idle_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      do_start(va[i], vb[i]);
      wait_rdy(lat, bcnt);
      chk($sformatf("vec%0d_lat", i), lat, 32'd32);
      chk($sformatf("vec%0d_result", i), data_result, vr[i]);
      chk($sformatf("vec%0d_exc", i), {31'd0, data_exception}, {31'd0, ve[i]});
    end

    // restart at cycle 10: only the second operation reports
    do_start(32'd6, 32'd7);
    rdy_seen = 0;
    repeat (9) begin
      @(posedge clock); #1;
      if (data_resultRDY) rdy_seen++;
    end
    chk("restart_result_held_in_run", data_result, 32'h0000_0000);
    do_start(32'd3, 32'd3);
    wait_rdy(lat, bcnt);
    chk("restart_early_rdy", rdy_seen, 32'd0);
    chk("restart_lat", lat, 32'd32);
    chk("restart_result", data_result, 32'd9);

    // ctrl_MULT held for three edges: latency counts from the last one
    @(negedge clock);
    data_operandA = 32'd4; data_operandB = 32'd4; ctrl_MULT = 1'b1;
    @(posedge clock); @(posedge clock);
    #1; data_operandA = 32'd5; data_operandB = 32'd5;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    wait_rdy(lat, bcnt);
    chk("held_lat", lat, 32'd32);
    chk("held_result", data_result, 32'd25);

    // asynchronous reset mid-run
    do_start(32'd6, 32'd7);
    repeat (19) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("midrst_result", data_result, 32'd0);
    chk("midrst_exc", {31'd0, data_exception}, 32'd0);
    chk("midrst_rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    rdy_seen = 0;
    bcnt = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (data_resultRDY) rdy_seen++;
      if (busy) bcnt++;
    end
    chk("midrst_no_rdy", rdy_seen, 32'd0);
    chk("midrst_no_busy", bcnt, 32'd0);

    // back-to-back: next start issued during the DONE cycle
    do_start(32'd6, 32'd7);
    wait_rdy(lat, bcnt);
    chk("b2b_first_lat", lat, 32'd32);
    chk("b2b_first_result", data_result, 32'd42);
    do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("b2b_result_held", data_result, 32'd42);
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait_rdy(lat, bcnt);
    chk("b2b_second_lat", lat, 32'd32);
    chk("b2b_second_result", data_result, 32'd1);
    chk("b2b_second_exc", {31'd0, data_exception}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
